cpu_stage_sequencer: RTL and testbench
======================================

CPU_STAGE_SEQUENCER -- requirements
Module: cpu_stage_sequencer

Interface
REQ-001 Parameter MAX_WAIT, default 8, SHALL set the cycles the block waits for mem_ready in FETCH or MEM before faulting (range 1..255).
REQ-002 Parameter CNT_W, default 32, SHALL set the width of the retired-instruction counter.
REQ-003 clk  in  1  SHALL be the only clock; all state changes on its rising edge.
REQ-004 rst  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 start  in  1  SHALL mean: begin execution; sampled in IDLE only.
REQ-006 is_load, is_store, is_branch, is_halt, writes_reg  in  1 each  SHALL be the decoded instruction class; valid in DECODE only.
REQ-007 mem_ready  in  1  SHALL mean: the memory completes the current read/write this cycle.
REQ-008 mem_rd, mem_wr  out  1  SHALL be the memory read and write requests.
REQ-009 ir_we, pc_we, rf_we, alu_en  out  1  SHALL be the instruction-register, PC, register-file write and ALU enables.
REQ-010 halted, fault  out  1  SHALL be the terminal status flags.
REQ-011 state  out  3  SHALL expose the current state code.
REQ-012 retired  out  CNT_W  SHALL count retired instructions.

Function
REQ-013 State codes SHALL be: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
REQ-014 IDLE: start=1 SHALL move to FETCH; otherwise stay.
REQ-015 FETCH: mem_rd=1 every cycle; on mem_ready, ir_we=1 in the same cycle and move to DECODE.
REQ-016 DECODE: the five class inputs SHALL be latched internally; later states use only the latched copies.
REQ-017 DECODE priority: is_halt -> HALT; else is_load and is_store both 1 -> FAULT; else -> EXEC.
REQ-018 EXEC: alu_en=1 for one cycle; next is MEM if load or store, else WB if writes_reg, else FETCH.
REQ-019 EXEC leaving to FETCH (branch or no-writeback op) SHALL assert pc_we=1 and increment retired in that cycle.
REQ-020 MEM: mem_rd=latched is_load and mem_wr=latched is_store every cycle; on mem_ready, a load goes to WB and a store goes to FETCH.
REQ-021 A store leaving MEM SHALL assert pc_we=1 and increment retired in that cycle.
REQ-022 WB: rf_we=1 and pc_we=1 for one cycle, increment retired, then go to FETCH.
REQ-023 HALT SHALL hold halted=1 and FAULT SHALL hold fault=1; both are absorbing until reset.
REQ-024 Wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_ready=0.
REQ-025 If mem_ready=0 in the MAX_WAIT-th cycle of a FETCH or MEM visit, the next state SHALL be FAULT.
REQ-026 mem_ready=1 in that same MAX_WAIT-th cycle SHALL win: the normal transition is taken.
REQ-027 ir_we, pc_we and rf_we SHALL each be 1 for exactly one cycle per event; all enables SHALL be 0 in IDLE, DECODE, HALT and FAULT.
REQ-028 With zero-wait memory, latencies SHALL be: branch 3, ALU with writeback 4, store 4, load 5 cycles, FETCH entry to next FETCH entry.
REQ-029 retired SHALL wrap from 2^CNT_W-1 to 0 without a flag.
REQ-030 mem_ready outside FETCH or MEM SHALL be ignored.

Reset
REQ-031 rst=0 SHALL immediately (without a clock) force state=IDLE, retired=0, wait counter=0, latched class=0, and all outputs 0.
REQ-032 Reset asserted mid-FETCH or mid-MEM SHALL abort the access: mem_rd and mem_wr drop to 0 asynchronously.
REQ-033 After rst returns to 1, the block SHALL stay in IDLE until start=1.

Verification
REQ-034 ALU op (writes_reg=1), mem_ready always 1, start pulse -> state sequence 1,2,3,5,1; rf_we and pc_we high in the WB cycle; retired=1.
REQ-035 Load, mem_ready delayed 3 cycles in MEM -> mem_rd high 4 cycles in MEM, then WB; retired=1; fault=0.
REQ-036 MAX_WAIT=8, mem_ready held 0 in FETCH -> state=7 after 8 FETCH cycles, fault=1.
REQ-037 Same setup, mem_ready=1 in the 8th cycle -> state=2 and fault stays 0.
REQ-038 is_halt=1 together with is_load=is_store=1 in DECODE -> state=6 and halted=1; retired is unchanged.
REQ-039 CNT_W=4, 16 branch instructions -> retired reads 0; then assert rst=0 mid-MEM -> state=0 and mem_rd=0 before the next clock edge.

Source files
------------

// File: rtl/cpu_stage_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB stepping with
// bounded memory waits, absorbing HALT/FAULT states and a retired counter.
module cpu_stage_sequencer #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_branch,
  input  logic             is_halt,
  input  logic             writes_reg,
  input  logic             mem_ready,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic             alu_en,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_e;

  // Wait count value held during the last permitted cycle of a memory visit.
  localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             ld_q, st_q, br_q, hl_q, wr_q;
  logic             ld_d, st_d, br_d, hl_d, wr_d;
  logic             wait_expired;

  // Branch and halt classes only steer DECODE; their latched copies are kept
  // so the whole decoded class is captured together.
  logic unused_cls;
  assign unused_cls = br_q ^ hl_q;

  assign wait_expired = (wait_q == WaitLast);
  assign state        = state_q;
  assign retired      = retired_q;

  // Next-state, datapath enables and counter updates for the current stage.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    ld_d      = ld_q;
    st_d      = st_q;
    br_d      = br_q;
    hl_d      = hl_q;
    wr_d      = wr_q;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    alu_en    = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_expired) state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        ld_d = is_load;
        st_d = is_store;
        br_d = is_branch;
        hl_d = is_halt;
        wr_d = writes_reg;
        if (is_halt)                   state_d = S_HALT;
        else if (is_load && is_store)  state_d = S_FAULT;
        else                           state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_en = 1'b1;
        if (ld_q || st_q) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else if (wr_q) begin
          state_d = S_WB;
        end else begin
          pc_we     = 1'b1;
          retired_d = retired_q + 1'b1;
          state_d   = S_FETCH;
          wait_d    = '0;
        end
      end
      S_MEM: begin
        mem_rd = ld_q;
        mem_wr = st_q;
        if (mem_ready) begin
          if (ld_q) begin
            state_d = S_WB;
          end else begin
            pc_we     = 1'b1;
            retired_d = retired_q + 1'b1;
            state_d   = S_FETCH;
            wait_d    = '0;
          end
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_expired) state_d = S_FAULT;
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        retired_d = retired_q + 1'b1;
        state_d   = S_FETCH;
        wait_d    = '0;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  // State, wait counter, retired counter and latched class registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      retired_q <= '0;
      ld_q      <= 1'b0;
      st_q      <= 1'b0;
      br_q      <= 1'b0;
      hl_q      <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      ld_q      <= ld_d;
      st_q      <= st_d;
      br_q      <= br_d;
      hl_q      <= hl_d;
      wr_q      <= wr_d;
    end
  end

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Scoreboard bench for cpu_stage_sequencer: the driver schedules each
// instruction from its class and memory wait counts, pushing the expected
// state per cycle and the expected completion record per instruction.
module tb_cpu_stage_sequencer;

  localparam int MW = 8;
  localparam int CW = 4;

  localparam int IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3;
  localparam int MEM = 4, WB = 5, HALT = 6, FAULTS = 7;
  localparam int K_RET = 0, K_HALT = 1, K_FAULT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic is_load = 1'b0, is_store = 1'b0, is_branch = 1'b0;
  logic is_halt = 1'b0, writes_reg = 1'b0, mem_ready = 1'b0;
  logic mem_rd, mem_wr, ir_we, pc_we, rf_we, alu_en, halted, fault;
  logic [2:0] state;
  logic [CW-1:0] retired;

  typedef struct {
    int kind; int lat; int nrd; int nwr; int nir; int rf; int ret;
  } item_t;

  item_t item_q[$];
  int    exp_st_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    model_ret = 0;

  cpu_stage_sequencer #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .is_halt(is_halt), .writes_reg(writes_reg), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_we(ir_we), .pc_we(pc_we),
    .rf_we(rf_we), .alu_en(alu_en), .halted(halted), .fault(fault),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rb();
    return $urandom_range(0, 1) == 1;
  endfunction

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 11));
    if (r < 7) return int'($urandom_range(0, 2));
    if (r < 9) return int'($urandom_range(3, 5));
    if (r == 9) return MW - 1;
    if (r == 10) return MW;
    return MW + 2;
  endfunction

  task automatic step(input int exp_st);
    exp_st_q.push_back(exp_st);
    @(posedge clk);
    #1;
  endtask

  task automatic junk_class();
    is_load = rb(); is_store = rb(); is_branch = rb();
    is_halt = rb(); writes_reg = rb();
  endtask

  task automatic tail(input int st);
    for (int i = 0; i < 3; i++) begin
      junk_class();
      mem_ready = rb();
      step(st);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("reset_state", int'(state), IDLE);
    chk("reset_retired", int'(retired), 0);
    chk("reset_outputs",
        int'({mem_rd, mem_wr, ir_we, pc_we, rf_we, alu_en, halted, fault}), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_ret = 0;
    start = 1'b0;
    for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
      junk_class();
      mem_ready = rb();
      step(IDLE);
    end
    start = 1'b1;
    step(IDLE);
    start = 1'b0;
  endtask

  // Instruction kinds: 0 alu+wb, 1 alu no wb, 2 branch, 3 load, 4 store,
  // 5 halt, 6 load+store (illegal), 7 halt with load+store.
  task automatic run_instr(input int fk, input int ffw, input int fmw, output bit term);
    int k, r, fw, mw, fcyc, mcyc;
    bit ld, st, br, hl, wr, fto, mto, mem;
    item_t it;
    if (fk < 0) begin
      r = int'($urandom_range(0, 19));
      k = r < 5 ? 0 : r < 8 ? 1 : r < 11 ? 2 : r < 15 ? 3 : r < 18 ? 4 : r == 18 ? 5 : 6;
    end else k = fk;
    fw = ffw < 0 ? pick_wait() : ffw;
    mw = fmw < 0 ? pick_wait() : fmw;
    ld = 0; st = 0; br = 0; hl = 0; wr = 0;
    case (k)
      0: begin wr = 1; br = rb(); end
      1: ;
      2: br = 1;
      3: begin ld = 1; wr = rb(); end
      4: begin st = 1; wr = rb(); end
      5: begin hl = 1; ld = rb(); st = rb(); wr = rb(); br = rb(); end
      6: begin ld = 1; st = 1; wr = rb(); br = rb(); end
      default: begin hl = 1; ld = 1; st = 1; end
    endcase
    fto  = fw >= MW;
    fcyc = fto ? MW : fw + 1;
    mto  = mw >= MW;
    mcyc = mto ? MW : mw + 1;
    mem  = (ld || st) && !hl && !(ld && st);
    it = '{kind: K_RET, lat: 0, nrd: fcyc, nwr: 0, nir: 1, rf: 0, ret: model_ret};
    if (fto) begin
      it.kind = K_FAULT; it.lat = fcyc + 1; it.nir = 0;
    end else if (hl) begin
      it.kind = K_HALT; it.lat = fcyc + 2;
    end else if (ld && st) begin
      it.kind = K_FAULT; it.lat = fcyc + 2;
    end else if (mem) begin
      if (ld) it.nrd += mcyc;
      if (st) it.nwr = mcyc;
      if (mto) begin it.kind = K_FAULT; it.lat = fcyc + 2 + mcyc + 1; end
      else if (ld) begin it.rf = 1; it.lat = fcyc + 2 + mcyc + 1; end
      else it.lat = fcyc + 2 + mcyc;
    end else if (wr) begin
      it.rf = 1; it.lat = fcyc + 3;
    end else it.lat = fcyc + 2;
    if (it.kind == K_RET) model_ret = (model_ret + 1) % (1 << CW);
    item_q.push_back(it);

    term = 1;
    for (int i = 0; i < fcyc; i++) begin
      junk_class();
      mem_ready = (!fto && i == fcyc - 1);
      step(FETCH);
    end
    if (fto) begin tail(FAULTS); return; end
    is_load = ld; is_store = st; is_branch = br; is_halt = hl; writes_reg = wr;
    mem_ready = rb();
    step(DECODE);
    if (hl) begin tail(HALT); return; end
    if (ld && st) begin tail(FAULTS); return; end
    junk_class();
    mem_ready = rb();
    step(EXEC);
    if (mem) begin
      for (int i = 0; i < mcyc; i++) begin
        junk_class();
        mem_ready = (!mto && i == mcyc - 1);
        step(MEM);
      end
      if (mto) begin tail(FAULTS); return; end
    end
    if (it.rf == 1) begin
      junk_class();
      mem_ready = rb();
      step(WB);
    end
    term = 0;
  endtask

  // Monitor: per-cycle state trace and per-instruction completion records.
  int cyc = 0, c_rd = 0, c_wr = 0, c_ir = 0;
  bit term_seen = 0;
  initial begin
    item_t e;
    int es, ka;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cyc = 0; c_rd = 0; c_wr = 0; c_ir = 0; term_seen = 0;
      end else begin
        if (exp_st_q.size() > 0) begin
          es = exp_st_q.pop_front();
          chk("state_trace", int'(state), es);
        end
        if (start) begin
          cyc = 0; c_rd = 0; c_wr = 0; c_ir = 0;
        end else begin
          cyc++;
          c_rd += int'(mem_rd); c_wr += int'(mem_wr); c_ir += int'(ir_we);
          if (!term_seen && (pc_we || halted || fault)) begin
            ka = halted ? K_HALT : (fault ? K_FAULT : K_RET);
            if (item_q.size() == 0) begin
              chk("unexpected_event", ka, -1);
            end else begin
              e = item_q.pop_front();
              chk("event_kind", ka, e.kind);
              chk("event_latency", cyc, e.lat);
              chk("mem_rd_cycles", c_rd, e.nrd);
              chk("mem_wr_cycles", c_wr, e.nwr);
              chk("ir_we_pulses", c_ir, e.nir);
              chk("rf_we_at_event", int'(rf_we), e.rf);
              chk("retired_at_event", int'(retired), e.ret);
            end
            cyc = 0; c_rd = 0; c_wr = 0; c_ir = 0;
            if (halted || fault) term_seen = 1;
          end
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit t;
    @(posedge clk);
    #1;
    do_reset();
    // ALU with writeback, zero-wait memory
    run_instr(0, 0, 0, t);
    chk("retired_after_alu", int'(retired), 1);
    // Load with three wait cycles in MEM
    run_instr(3, 0, 3, t);
    chk("retired_after_load", int'(retired), 2);
    // Halt wins over illegal load+store
    run_instr(7, 0, 0, t);
    chk("halted_flag", int'(halted), 1);
    chk("retired_at_halt", int'(retired), 2);
    do_reset();
    // Ready in the last permitted fetch cycle, then a timeout
    run_instr(2, MW - 1, 0, t);
    run_instr(2, MW, 0, t);
    chk("fault_flag", int'(fault), 1);
    do_reset();
    // Retired counter wraps after 2^CW branches
    for (int i = 0; i < 16; i++) run_instr(2, 0, 0, t);
    chk("retired_wrap", int'(retired), 0);
    // Reset asserted mid-MEM aborts the access without a clock edge
    junk_class(); mem_ready = 1'b1; step(FETCH);
    is_load = 1; is_store = 0; is_halt = 0; is_branch = 0; writes_reg = 1;
    mem_ready = 1'b0; step(DECODE);
    step(EXEC);
    #1;
    chk("mid_mem_state", int'(state), MEM);
    chk("mid_mem_rd", int'(mem_rd), 1);
    rst = 1'b0;
    #1;
    chk("abort_state", int'(state), IDLE);
    chk("abort_mem_rd", int'(mem_rd), 0);
    chk("abort_retired", int'(retired), 0);
    // Randomized episodes
    for (int ep = 0; ep < 15; ep++) begin
      do_reset();
      for (int n = 0; n < 30; n++) begin
        run_instr(-1, -1, -1, t);
        if (t) break;
      end
    end
    @(posedge clk);
    #1;
    chk("pending_records", item_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
